dct2d_sched: RTL and testbench

DCT2D_SCHED -- requirements
Module: dct2d_sched

---
 rtl/dct2d_sched.sv | 134 +++++++++++++
 tb/tb_dct2d_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct2d_sched.sv
// 2-D DCT row/column scheduler around a shared 1-D DCT core.
// Rows pass through the core into a transpose buffer; columns are re-issued from it.
module dct2d_sched #(
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0][DW-1:0] in_data,
  output logic               core_in_valid,
  input  logic               core_in_ready,
  output logic [7:0][DW-1:0] core_in_data,
  input  logic               core_out_valid,
  output logic               core_out_ready,
  input  logic [7:0][DW-1:0] core_out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0][DW-1:0] out_data,
  output logic               out_last,
  output logic               busy
);

  localparam logic [0:0] ROW = 1'b0;
  localparam logic [0:0] COL = 1'b1;

  logic [0:0]        state;
  logic [3:0]        rows_issued;
  logic [3:0]        rows_done;
  logic [3:0]        cols_issued;
  logic [3:0]        cols_done;
  logic [DW-1:0]     tbuf [8][8];
  logic [7:0][DW-1:0] col_vec;
  logic              cin_hs;
  logic              cout_hs;
  logic              out_hs;

  function automatic logic [3:0] sat_inc(input logic [3:0] x);
    return (x >= 4'd8) ? 4'd8 : x + 4'd1;
  endfunction

  // Column c of the block is lane-wise row k, column c of the buffer.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      col_vec[k] = tbuf[k][cols_issued[2:0]];
    end
  end

  always_comb begin
    in_ready       = 1'b0;
    core_in_valid  = 1'b0;
    core_in_data   = '0;
    core_out_ready = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_last       = 1'b0;
    if (!rst) begin
      unique case (state)
        ROW: begin
          in_ready       = core_in_ready && (rows_issued < 4'd8);
          core_in_valid  = in_valid && (rows_issued < 4'd8);
          core_in_data   = in_data;
          core_out_ready = 1'b1;
        end
        COL: begin
          core_in_valid  = cols_issued < 4'd8;
          core_in_data   = col_vec;
          core_out_ready = out_ready;
          out_valid      = core_out_valid;
          out_data       = core_out_data;
          out_last       = core_out_valid && (cols_done == 4'd7);
        end
        default: ;
      endcase
    end
  end

  assign cin_hs  = core_in_valid && core_in_ready;
  assign cout_hs = core_out_valid && core_out_ready;
  assign out_hs  = out_valid && out_ready;
  assign busy    = (state == COL) || (rows_issued != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ROW;
      rows_issued <= 4'd0;
      rows_done   <= 4'd0;
      cols_issued <= 4'd0;
      cols_done   <= 4'd0;
    end else begin
      unique case (state)
        ROW: begin
          if (cin_hs) begin
            rows_issued <= sat_inc(rows_issued);
          end
          if (cout_hs) begin
            if (rows_done == 4'd7) begin
              state       <= COL;
              rows_issued <= 4'd0;
              rows_done   <= 4'd0;
            end else begin
              rows_done <= sat_inc(rows_done);
            end
          end
        end
        COL: begin
          if (cin_hs) begin
            cols_issued <= sat_inc(cols_issued);
          end
          if (out_hs) begin
            if (cols_done == 4'd7) begin
              state       <= ROW;
              cols_issued <= 4'd0;
              cols_done   <= 4'd0;
            end else begin
              cols_done <= sat_inc(cols_done);
            end
          end
        end
        default: state <= ROW;
      endcase
    end
  end

  // Buffer holds no control state, so it is left unreset.
  always_ff @(posedge clk) begin
    if ((state == ROW) && cout_hs) begin
      for (int k = 0; k < 8; k++) begin
        tbuf[rows_done[2:0]][k] <= core_out_data[k];
      end
    end
  end

endmodule

// File: tb/tb_dct2d_sched.sv
// Randomised bench for dct2d_sched with a queued latency core model.
// Expected vectors come from a block-level transform model.
module tb_dct2d_sched;
  localparam int DW = 32;
  typedef logic [7:0][DW-1:0] vec_t;
  typedef struct {
    vec_t d;
    int   t;
  } cq_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  vec_t in_data;
  logic core_in_valid, core_in_ready;
  vec_t core_in_data;
  logic core_out_valid, core_out_ready;
  vec_t core_out_data;
  logic out_valid, out_ready, out_last, busy;
  vec_t out_data;

  dct2d_sched #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_in_data(core_in_data),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .core_out_data(core_out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   lat = 3;
  int   cir_mode = 0;
  int   or_mode = 0;
  int   stall_left = 0;
  int   stall_seen = 0;
  int   cin = 0;
  int   cout = 0;
  logic blk_active = 1'b0;
  vec_t src_q[$];
  vec_t exp_cin[$];
  vec_t exp_out[$];
  vec_t got_q[$];
  cq_t  cq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkv(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stand-in 1-D transform: any lane-wise map keeps rows and columns distinguishable.
  function automatic vec_t f(input vec_t v);
    vec_t r;
    for (int k = 0; k < 8; k++) r[k] = v[k] * DW'(3) + DW'(k);
    return r;
  endfunction

  task automatic push_block(input vec_t blk [8]);
    vec_t rr [8];
    vec_t col;
    for (int r = 0; r < 8; r++) begin
      src_q.push_back(blk[r]);
      exp_cin.push_back(blk[r]);
      rr[r] = f(blk[r]);
    end
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) col[k] = rr[k][c];
      exp_cin.push_back(col);
      exp_out.push_back(f(col));
    end
  endtask

  task automatic drive();
    in_valid = src_q.size() > 0;
    in_data  = in_valid ? src_q[0] : '0;
    case (cir_mode)
      1:       core_in_ready = (cyc % 2) == 0;
      2:       core_in_ready = $urandom_range(0, 3) != 0;
      default: core_in_ready = 1'b1;
    endcase
    case (or_mode)
      1: begin
        if (cout == 11 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      2:       out_ready = $urandom_range(0, 2) != 0;
      default: out_ready = 1'b1;
    endcase
    core_out_valid = cq.size() > 0 && cq[0].t <= cyc;
    core_out_data  = core_out_valid ? cq[0].d : '0;
  endtask

  task automatic step();
    logic ih, cih, coh, oh, done, ov_exp;
    vec_t cid, od;
    @(negedge clk);
    ov_exp = (cout >= 8) && core_out_valid;
    chk("in_ready", in_ready, core_in_ready && cin < 8 && cout < 8);
    chk("core_in_valid", core_in_valid,
        (cout < 8) ? (in_valid && cin < 8) : (cin < 16));
    chk("core_out_ready", core_out_ready, (cout < 8) ? 1'b1 : out_ready);
    chk("out_valid", out_valid, ov_exp);
    chk("out_last", out_last, ov_exp && cout == 15);
    chk("busy", busy, blk_active);
    if (cout >= 8 && !out_ready) stall_seen++;
    ih  = in_valid && in_ready;
    cih = core_in_valid && core_in_ready;
    coh = core_out_valid && core_out_ready;
    oh  = out_valid && out_ready;
    cid = core_in_data;
    od  = out_data;
    if (cih) begin
      if (exp_cin.size() > 0) chkv("core_in_data", cid, exp_cin[0]);
      else chk("core_in_extra", 1'b1, 1'b0);
    end
    if (oh) begin
      if (exp_out.size() > 0) chkv("out_data", od, exp_out[0]);
      else chk("out_extra", 1'b1, 1'b0);
    end
    @(posedge clk);
    done = oh && cout == 15;
    if (ih) begin
      void'(src_q.pop_front());
      blk_active = 1'b1;
    end
    if (cih) begin
      cq.push_back('{d: f(cid), t: cyc + lat});
      if (exp_cin.size() > 0) void'(exp_cin.pop_front());
      cin++;
    end
    if (coh) begin
      void'(cq.pop_front());
      cout++;
    end
    if (oh) begin
      got_q.push_back(od);
      if (exp_out.size() > 0) void'(exp_out.pop_front());
    end
    if (done) begin
      cin = 0;
      cout = 0;
      blk_active = 1'b0;
    end
    cyc++;
    #1 drive();
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    while ((src_q.size() > 0 || exp_out.size() > 0) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d cycles expected < %0d", n, maxc);
    end
    repeat (2) step();
  endtask

  task automatic rand_block(output vec_t blk [8]);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) blk[r][k] = $urandom;
  endtask

  vec_t lit [8];
  vec_t rb [8];
  int   base;
  int   base2;
  int   n;

  initial begin
    rst = 1'b1;
    drive();
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_in_valid", core_in_valid, 1'b0);
    chk("rst_core_out_ready", core_out_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    rst = 1'b0;
    drive();

    // Literal block: row r lane k = 8r+k gives output column c lane k = 73k+12c.
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) lit[r][k] = DW'(8 * r + k);
    base = got_q.size();
    push_block(lit);
    chk("model_pin_c3k5", 64'(exp_out[3][5]), 64'd401);
    chk("model_cin_c2k4", 64'(exp_cin[10][4]), 64'd104);
    drive();
    run_idle(300);
    chk("lit_count", 64'(got_q.size() - base), 64'd8);
    if (got_q.size() >= base + 8) begin
      chk("lit_c0k0", 64'(got_q[base][0]), 64'd0);
      chk("lit_c3k5", 64'(got_q[base + 3][5]), 64'd401);
      chk("lit_c7k7", 64'(got_q[base + 7][7]), 64'd595);
      chk("lit_c1k2", 64'(got_q[base + 1][2]), 64'd158);
    end

    cir_mode = 1;
    rand_block(rb);
    push_block(rb);
    rand_block(rb);
    push_block(rb);
    drive();
    run_idle(800);

    cir_mode = 0;
    or_mode = 1;
    stall_left = 10;
    stall_seen = 0;
    rand_block(rb);
    push_block(rb);
    drive();
    run_idle(400);
    chk("stall_cycles", 64'(stall_seen), 64'd10);

    cir_mode = 2;
    or_mode = 2;
    lat = 4;
    for (int b = 0; b < 3; b++) begin
      rand_block(rb);
      push_block(rb);
    end
    drive();
    run_idle(3000);

    cir_mode = 0;
    or_mode = 0;
    lat = 3;
    rand_block(rb);
    push_block(rb);
    drive();
    n = 0;
    while (cin < 5 && n < 100) begin
      step();
      n++;
    end
    chk("pre_rst_rows", 64'(cin), 64'd5);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_core_in_valid", core_in_valid, 1'b0);
    chk("mid_rst_core_out_ready", core_out_ready, 1'b0);
    src_q.delete();
    exp_cin.delete();
    exp_out.delete();
    cq.delete();
    cin = 0;
    cout = 0;
    blk_active = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy_next", busy, 1'b0);
    rst = 1'b0;
    base = got_q.size();
    push_block(lit);
    drive();
    run_idle(300);
    chk("post_rst_count", 64'(got_q.size() - base), 64'd8);
    if (got_q.size() >= base + 8)
      chk("post_rst_c3k5", 64'(got_q[base + 3][5]), 64'd401);

    rand_block(rb);
    lat = 1;
    base = got_q.size();
    push_block(rb);
    drive();
    run_idle(300);
    lat = 7;
    base2 = got_q.size();
    push_block(rb);
    drive();
    run_idle(400);
    chk("lat_counts", 64'(got_q.size() - base2), 64'(base2 - base));
    if (got_q.size() >= base2 + 8 && base2 >= base + 8)
      for (int c = 0; c < 8; c++)
        chkv("lat1_vs_lat7", got_q[base2 + c], got_q[base + c]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
